// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler
// Holds a host-writable shadow of the 9 colour bytes for three WS2812 LEDs.
// Frames are requested by an explicit commit or by the periodic refresh tick.
// Each frame latches brightness-scaled colours, pulses the driver start and
// then follows the driver ready handshake, with a timeout while waiting busy.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no frame running; waits for pending request and ready driver
// S_LATCH     | scaled colours loaded into the output registers
// S_START     | start pulse issued next cycle, timeout counter cleared
// S_WAIT_BUSY | waiting for driver ready to fall (bounded by BUSY_TIMEOUT)
// S_WAIT_DONE | waiting for driver ready to rise again (frame complete)
module ws2812_frame_scheduler #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int REFRESH_HZ      = 30,
  parameter int BUSY_TIMEOUT    = 1024
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Wr,
  input  logic [3:0] i_Addr,
  input  logic [7:0] i_Data,
  input  logic       i_Commit,
  input  logic       i_Auto_Refresh,
  input  logic [7:0] i_Brightness,
  input  logic       i_Driver_Ready,
  output logic       o_Start,
  output logic [7:0] o_LED1_R,
  output logic [7:0] o_LED1_G,
  output logic [7:0] o_LED1_B,
  output logic [7:0] o_LED2_R,
  output logic [7:0] o_LED2_G,
  output logic [7:0] o_LED2_B,
  output logic [7:0] o_LED3_R,
  output logic [7:0] o_LED3_G,
  output logic [7:0] o_LED3_B,
  output logic       o_Busy,
  output logic       o_Frame_Done,
  output logic       o_Error
);

  localparam int REFRESH_PERIOD = CLOCK_FREQUENCY / REFRESH_HZ;
  localparam int REFRESH_W      = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int TIMEOUT_W      = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_PERIOD - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_shadow [0:8];
  logic [7:0]            r_led    [0:8];
  logic [REFRESH_W-1:0]  r_refresh_cnt;
  logic [TIMEOUT_W-1:0]  r_timeout_cnt;
  logic                  r_pending;
  logic                  r_start;
  logic                  r_frame_done;
  logic                  r_error;
  logic                  w_tick;
  logic                  w_timeout;
  logic [8:0]            w_mult;

  assign w_tick    = (r_refresh_cnt == REFRESH_LAST);
  assign w_timeout = (r_state == S_WAIT_BUSY) && i_Driver_Ready &&
                     (r_timeout_cnt == TIMEOUT_LAST);
  assign w_mult    = {1'b0, i_Brightness} + 9'd1;

  // Top byte of colour x (brightness+1): 255 is identity, 0 is black.
  function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [8:0] m);
    logic [16:0] p;
    p = 17'(c) * 17'(m);
    return p[15:8];
  endfunction

  // Host writes to the shadow copy; addresses above 8 are ignored.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < 9; i++) r_shadow[i] <= 8'd0;
    end else if (i_Wr && (i_Addr <= 4'd8)) begin
      r_shadow[i_Addr] <= i_Data;
    end
  end

  // Free-running refresh counter; wrap produces the refresh tick.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_refresh_cnt <= '0;
    end else if (w_tick) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // Request flag; a new request wins over the clear so none is lost.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_pending <= 1'b0;
    end else if (i_Commit || (w_tick && i_Auto_Refresh)) begin
      r_pending <= 1'b1;
    end else if (r_state == S_LATCH) begin
      r_pending <= 1'b0;
    end
  end

  // Busy timeout counter, restarted for every frame.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_timeout_cnt <= '0;
    end else if (r_state == S_START) begin
      r_timeout_cnt <= '0;
    end else if (r_state == S_WAIT_BUSY) begin
      r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (r_pending && i_Driver_Ready) w_next_state = S_LATCH;
      S_LATCH:     w_next_state = S_START;
      S_START:     w_next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i_Driver_Ready) w_next_state = S_WAIT_DONE;
        else if (w_timeout)  w_next_state = S_IDLE;
      end
      S_WAIT_DONE: if (i_Driver_Ready) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs: colours only change in LATCH, pulses and sticky error.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < 9; i++) r_led[i] <= 8'd0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (r_state == S_LATCH) begin
        for (int i = 0; i < 9; i++) r_led[i] <= f_scale(r_shadow[i], w_mult);
      end
      r_start      <= (r_state == S_START);
      r_frame_done <= (r_state == S_WAIT_DONE) && i_Driver_Ready;
      if (w_timeout)     r_error <= 1'b1;
      else if (i_Commit) r_error <= 1'b0;
    end
  end

  assign o_Start      = r_start;
  assign o_Frame_Done = r_frame_done;
  assign o_Error      = r_error;
  assign o_Busy       = (r_state != S_IDLE);
  assign o_LED1_R     = r_led[0];
  assign o_LED1_G     = r_led[1];
  assign o_LED1_B     = r_led[2];
  assign o_LED2_R     = r_led[3];
  assign o_LED2_G     = r_led[4];
  assign o_LED2_B     = r_led[5];
  assign o_LED3_R     = r_led[6];
  assign o_LED3_G     = r_led[7];
  assign o_LED3_B     = r_led[8];

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Testbench for ws2812_frame_scheduler: expected frames are queued when a
// frame is requested and compared by a monitor at every start pulse.
module tb_ws2812_frame_scheduler;

  localparam int CF = 3000;
  localparam int RH = 30;
  localparam int BT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] data;
  logic       commit;
  logic       auto_r;
  logic [7:0] bright;
  logic       ready;
  logic       start;
  logic [7:0] l1r, l1g, l1b, l2r, l2g, l2b, l3r, l3g, l3b;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int passes = 0;
  int start_count = 0;
  int cyc = 0;
  bit stuck = 1'b0;
  logic [71:0] exp_q [$];

  ws2812_frame_scheduler #(
    .CLOCK_FREQUENCY(CF), .REFRESH_HZ(RH), .BUSY_TIMEOUT(BT)
  ) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Wr(wr), .i_Addr(addr), .i_Data(data),
    .i_Commit(commit), .i_Auto_Refresh(auto_r), .i_Brightness(bright),
    .i_Driver_Ready(ready), .o_Start(start),
    .o_LED1_R(l1r), .o_LED1_G(l1g), .o_LED1_B(l1b),
    .o_LED2_R(l2r), .o_LED2_G(l2g), .o_LED2_B(l2b),
    .o_LED3_R(l3r), .o_LED3_G(l3g), .o_LED3_B(l3b),
    .o_Busy(busy), .o_Frame_Done(done), .o_Error(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  // Monitor: every start pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (start === 1'b1) begin
      logic [71:0] act;
      logic [71:0] expv;
      start_count++;
      act = {l1r, l1g, l1b, l2r, l2g, l2b, l3r, l3g, l3b};
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_start: got frame 0x%0h expected none", act);
      end else begin
        expv = exp_q.pop_front();
        for (int i = 0; i < 9; i++)
          check($sformatf("led_byte%0d", i), 32'(act[71-8*i -: 8]), 32'(expv[71-8*i -: 8]));
      end
    end
  end

  // Driver model: after a start it drops ready for a while, unless stuck.
  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && !stuck) begin
        repeat (3) @(negedge clk);
        ready = 1'b0;
        repeat (20) @(negedge clk);
        ready = 1'b1;
      end
    end
  end

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; data = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_start(input string name, output int at);
    int n = 0;
    while (start !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    at = cyc;
    check(name, 32'(start), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check(name, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_ready_low(input string name);
    int n = 0;
    while (ready !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check(name, 32'(ready), 32'd0);
    @(negedge clk);
  endtask

  localparam logic [71:0] FRAME_B = 72'hAA_02_03_04_05_06_07_08_55;

  initial begin
    int t0, t1, t2;
    rst_n = 1'b0; wr = 1'b0; addr = 4'd0; data = 8'd0; commit = 1'b0;
    auto_r = 1'b0; bright = 8'd255;
    repeat (3) @(negedge clk);
    check("rst_leds", 32'({l1r, l2g, l3b}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({start, done, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame and commit-to-start latency.
    write(4'd0, 8'h80);
    write(4'd4, 8'h40);
    write(4'd9, 8'hFF);
    exp_q.push_back(72'h80_00_00_00_40_00_00_00_00);
    do_commit();
    check("busy_k0", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_k1", 32'(busy), 32'd1);
    check("start_k1", 32'(start), 32'd0);
    @(negedge clk);
    check("start_k2", 32'(start), 32'd0);
    check("led1r_k2", 32'(l1r), 32'h80);
    @(negedge clk);
    check("start_k3", 32'(start), 32'd1);
    @(negedge clk);
    check("start_k4", 32'(start), 32'd0);
    wait_done("done_t1");

    // Brightness scaling.
    for (int i = 0; i < 9; i++) write(4'(i), 8'hFF);
    bright = 8'h7F;
    exp_q.push_back({9{8'h7F}});
    do_commit();
    wait_done("done_t2a");
    bright = 8'h00;
    exp_q.push_back(72'd0);
    do_commit();
    wait_done("done_t2b");

    // Requests merging during a frame, writes not touching held outputs.
    bright = 8'd255;
    for (int i = 0; i < 9; i++) write(4'(i), 8'(i + 1));
    exp_q.push_back(72'h01_02_03_04_05_06_07_08_09);
    do_commit();
    wait_ready_low("ready_low_t3");
    do_commit();
    do_commit();
    write(4'd0, 8'hAA);
    write(4'd8, 8'h55);
    do_commit();
    exp_q.push_back(FRAME_B);
    check("hold_led1r", 32'(l1r), 32'h01);
    check("hold_led3b", 32'(l3b), 32'h09);
    wait_done("done_t3a");
    wait_done("done_t3b");
    repeat (60) @(negedge clk);
    check("start_count_t3", 32'(start_count), 32'd5);

    // Busy timeout, then recovery with a good driver.
    stuck = 1'b1;
    exp_q.push_back(FRAME_B);
    do_commit();
    wait_start("start_t4", t0);
    begin
      int n = 0;
      while (err !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      t1 = cyc;
      check("err_set", 32'(err), 32'd1);
    end
    check("timeout_cycles", 32'(t1 - t0), 32'(BT));
    check("busy_after_to", 32'(busy), 32'd0);
    check("held_after_to", 32'({l1r, l3b}), 32'hAA55);
    stuck = 1'b0;
    @(negedge clk);
    exp_q.push_back(FRAME_B);
    do_commit();
    check("err_cleared", 32'(err), 32'd0);
    wait_done("done_t4");
    check("err_after_good", 32'(err), 32'd0);

    // Auto refresh every CF/RH clocks.
    repeat (3) exp_q.push_back(FRAME_B);
    auto_r = 1'b1;
    wait_start("auto_start1", t0);
    wait_start("auto_start2", t1);
    wait_start("auto_start3", t2);
    auto_r = 1'b0;
    check("auto_period1", 32'(t1 - t0), 32'(CF / RH));
    check("auto_period2", 32'(t2 - t1), 32'(CF / RH));
    repeat (300) @(negedge clk);
    check("start_count_t5", 32'(start_count), 32'd10);

    // Reset during WAIT_DONE.
    exp_q.push_back(FRAME_B);
    do_commit();
    wait_ready_low("ready_low_t6");
    check("busy_wait_done", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst6_leds", 32'({l1r, l1g, l1b, l2r}), 32'd0);
    check("rst6_leds2", 32'({l2g, l2b, l3r, l3g}), 32'd0);
    check("rst6_l3b", 32'(l3b), 32'd0);
    check("rst6_busy", 32'(busy), 32'd0);
    check("rst6_flags", 32'({start, done, err}), 32'd0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("start_count_end", 32'(start_count), 32'd11);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_scheduler.md
# ws2812_frame_scheduler

Frame controller that sits between the UART command decoder and the 3-LED WS2812 serial driver. It holds a host-writable shadow copy of the 9 colour bytes and applies a global brightness scale. It sequences driver frames on explicit commit or a periodic refresh tick, running the driver's start/ready handshake with a busy timeout. The driver only ever sees stable colour inputs for the duration of a frame.

## Interface
- CLOCK_FREQUENCY, 100000000, system clock in Hz
- REFRESH_HZ, 30, auto-refresh frame rate
- BUSY_TIMEOUT, 1024, clocks allowed for driver ready to fall after o_Start

- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset_n  in  1  reset: one clock; reset is synchronous and active-low
- i_Wr  in  1  shadow register write strobe, one byte per cycle
- i_Addr  in  4  shadow address: 0..8 = LED1 R,G,B, LED2 R,G,B, LED3 R,G,B
- i_Data  in  8  write data
- i_Commit  in  1  request a frame with current shadow contents
- i_Auto_Refresh  in  1  enable periodic frames at REFRESH_HZ
- i_Brightness  in  8  global scale, sampled at LATCH
- i_Driver_Ready  in  1  driver ready (updated on driver's slow bit clock)
- o_Start  out  1  one-cycle start pulse to driver
- o_LED1_R/G/B, o_LED2_R/G/B, o_LED3_R/G/B  out  8 each  scaled colours to driver
- o_Busy  out  1  high whenever state != IDLE
- o_Frame_Done  out  1  one-cycle pulse at frame completion
- o_Error  out  1  sticky busy-timeout flag

## Operation
- Reset (i_Reset_n low at an edge): shadow regs, all o_LED*, o_Start, o_Frame_Done, o_Error = 0; pending = 0; refresh counter = 0; state IDLE.
- Writes: i_Wr with i_Addr 0..8 updates that shadow byte; addr 9..15 ignored. Writes accepted in any state; they never alter o_LED* outside LATCH.
- Pending flag: set by i_Commit, or by refresh tick when i_Auto_Refresh = 1. Cleared in LATCH. Multiple requests before LATCH merge into one frame. A request during a frame sets pending, giving exactly one further frame.
- Refresh counter: free-running 0..CLOCK_FREQUENCY/REFRESH_HZ-1, tick on wrap. A tick with i_Auto_Refresh = 0 is discarded.
- States:
  - IDLE: go to LATCH when pending = 1 and i_Driver_Ready = 1. Otherwise stay.
  - LATCH: each o_LED byte = bits [15:8] of shadow × (i_Brightness + 1). Uses 17-bit product, 9-bit multiplier. Brightness 255 gives identity; 0 gives 0. Clear pending; go to START.
  - START: assert o_Start on next cycle; clear timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: on i_Driver_Ready = 0, go to WAIT_DONE. If counter reaches BUSY_TIMEOUT-1 first, set o_Error and go to IDLE with o_LED* held.
  - WAIT_DONE: on i_Driver_Ready = 1, pulse o_Frame_Done and go to IDLE. No timeout here.
- Same-cycle write and LATCH: LATCH uses the pre-write shadow value; the write lands in shadow and appears next frame.
- i_Commit sampled high clears o_Error; a timeout in that frame sets it again.
- Reset mid-frame: immediate return to reset values; driver may finish its frame with zeroed colours.

## Timing
- i_Commit sampled at edge N with IDLE and ready high: LATCH state after N+1, o_LED* valid after N+2, o_Start high for exactly the cycle after N+3.
- o_LED* stable from LATCH until the next LATCH (whole frame).
- o_Frame_Done high one cycle after the edge that sees i_Driver_Ready rise in WAIT_DONE.
- o_Busy combinational from state. All other outputs registered.

## Test plan
- Write 0x80 to addr 0, 0x40 to addr 4; brightness 255; commit -> o_LED1_R = 0x80, o_LED2_G = 0x40, others 0; one o_Start pulse 3 cycles after commit.
- Brightness 0x7F, shadow byte 0xFF -> output 0x7F. Brightness 0 -> all outputs 0x00.
- Three commits plus writes during WAIT_DONE -> exactly one extra frame, carrying the post-write values.
- Driver model keeps ready high after o_Start -> o_Error = 1 after BUSY_TIMEOUT cycles, state IDLE. Next commit with a good driver clears o_Error and pulses o_Frame_Done.
- CLOCK_FREQUENCY = 3000, REFRESH_HZ = 30, auto on -> frame every 100 clocks. Auto off -> no frames.
- Reset asserted in WAIT_DONE -> next edge: all outputs 0, state IDLE, pending 0.
